// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: mono PCM samples are played in both slots, with a one-entry holding buffer.
// Build option: define I2S_UNDERRUN_HOLD_EN to repeat the last sample on underrun (default: silence).
module i2s_dac_serializer #(
  parameter int unsigned BCLK_DIV    = 4,
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned SLOT_BITS   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SAMPLE_BITS-1:0] sample_data,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   aud_bclk,
  output logic                   aud_daclrck,
  output logic                   aud_dacdat,
  output logic                   underrun
);

  localparam int unsigned DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BW = $clog2(2 * SLOT_BITS);
  localparam int unsigned IW = $clog2(SAMPLE_BITS);

  localparam logic [DW-1:0] DivLast = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DivHalf = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BitLast = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SlotB   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] SampB   = BW'(SAMPLE_BITS);

  logic [DW-1:0]          div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   bclk_q, bclk_d;
  logic                   lrck_q, lrck_d;
  logic                   dat_q, dat_d;
  logic                   under_q, under_d;
  logic                   full_q, full_d;
  logic                   ready_q, ready_d;
  logic [SAMPLE_BITS-1:0] buf_q, buf_d;
  logic [SAMPLE_BITS-1:0] word_q, word_d;

  logic          fall, fs, accept;
  logic [BW-1:0] pos;
  logic [IW-1:0] idx;

  always_comb begin
    fall   = (div_q == DivLast);
    fs     = fall && (bit_q == BitLast);
    accept = sample_valid && ready_q;

    div_d = fall ? '0 : div_q + DW'(1);
    bit_d = bit_q;
    if (fall) begin
      bit_d = (bit_q == BitLast) ? '0 : bit_q + BW'(1);
    end
    bclk_d = (div_d >= DivHalf);
    lrck_d = (bit_d >= SlotB);

    // Slot position of the bit about to be driven; position 0 is the I2S one-bit MSB delay.
    pos = lrck_d ? bit_d - SlotB : bit_d;
    idx = IW'(SampB - pos);
    dat_d = dat_q;
    if (fall) begin
      dat_d = ((pos != '0) && (pos <= SampB)) ? word_q[idx] : 1'b0;
    end

    buf_d   = buf_q;
    full_d  = full_q;
    word_d  = word_q;
    under_d = 1'b0;
    // The frame-start decision looks at the buffer state before this edge, so a sample
    // accepted on the same clock waits for the following frame.
    if (fs) begin
      if (full_q) begin
        word_d = buf_q;
        full_d = 1'b0;
      end else begin
        under_d = 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
        word_d = word_q;
`else
        word_d = '0;
`endif
      end
    end
    if (accept) begin
      buf_d  = sample_data;
      full_d = 1'b1;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      dat_q   <= 1'b0;
      under_q <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      buf_q   <= '0;
      word_q  <= '0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lrck_q  <= lrck_d;
      dat_q   <= dat_d;
      under_q <= under_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
    end
  end

  assign sample_ready = ready_q;
  assign aud_bclk     = bclk_q;
  assign aud_daclrck  = lrck_q;
  assign aud_dacdat   = dat_q;
  assign underrun     = under_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed bench for i2s_dac_serializer at default parameters (frame = 256 clk).
module tb_i2s_dac_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun;

  i2s_dac_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          edge_n = 0;
  logic [15:0] pend[$];
  int          acc_edge[$];
  logic        ready_k1;

  typedef struct {
    int          n_push;
    logic [15:0] push0;
    logic [15:0] push1;
    logic [15:0] exp_word;
    logic        exp_under;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock: present the head of the pending queue, advance, note acceptance.
  task automatic tick();
    logic acc;
    if (pend.size() > 0) begin
      sample_valid = 1'b1;
      sample_data  = pend[0];
    end else begin
      sample_valid = 1'b0;
      sample_data  = '0;
    end
    acc = sample_valid && sample_ready;
    @(posedge clk);
    #1;
    edge_n++;
    if (acc) begin
      void'(pend.pop_front());
      acc_edge.push_back(edge_n);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [15:0] w);
    logic [63:0] v;
    int          p;
    v = '0;
    for (int b = 0; b < 64; b++) begin
      p = b % 32;
      if (p >= 1 && p <= 16) v[b] = w[16-p];
    end
    return v;
  endfunction

  // Called right after a frame-start edge; returns right after the next one.
  task automatic run_frame(input string name, input logic [15:0] exp_word, input logic exp_under,
                           input bit late, input logic [15:0] late_data);
    logic [63:0] cap;
    int          bad;
    cap = '0;
    bad = 0;
    check({name, " underrun at frame start"}, 64'(underrun), 64'(exp_under));
    for (int k = 1; k <= 256; k++) begin
      if (late && k == 256) pend.push_back(late_data);
      tick();
      if (k == 1) ready_k1 = sample_ready;
      if (k < 256) begin
        if (k % 4 == 2) cap[k/4] = aud_dacdat;
        if (aud_bclk !== (k % 4 >= 2)) bad++;
        if (aud_daclrck !== (k >= 128)) bad++;
        if (underrun !== 1'b0) bad++;
      end
    end
    check({name, " data"}, cap, frame_bits(exp_word));
    check({name, " bclk/lrck/underrun timing errors"}, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    pend.delete();
    acc_edge.delete();
    repeat (3) @(posedge clk);
    #1;
    check("outputs during reset",
          64'({sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  initial begin
    logic [15:0] w_f3, w_f6;
`ifdef I2S_UNDERRUN_HOLD_EN
    w_f3 = 16'h8001;
    w_f6 = 16'hfaad;
`else
    w_f3 = 16'h0000;
    w_f6 = 16'h0000;
`endif
    tbl[0] = '{0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1, 16'h8001, 16'h0000, 16'h0000, 1'b1};
    tbl[2] = '{0, 16'h0000, 16'h0000, 16'h8001, 1'b0};
    tbl[3] = '{2, 16'h016b, 16'hfaad, w_f3,     1'b1};
    tbl[4] = '{0, 16'h0000, 16'h0000, 16'h016b, 1'b0};
    tbl[5] = '{0, 16'h0000, 16'h0000, 16'hfaad, 1'b0};
    tbl[6] = '{1, 16'h5555, 16'h0000, w_f6,     1'b1};

    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].n_push >= 1) pend.push_back(tbl[i].push0);
      if (tbl[i].n_push >= 2) pend.push_back(tbl[i].push1);
      run_frame($sformatf("frame %0d", i), tbl[i].exp_word, tbl[i].exp_under, 1'b0, 16'h0);
      if (i == 0) check("ready one clk after reset", 64'(ready_k1), 64'd1);
    end
    check("accept count", 64'(acc_edge.size()), 64'd4);
    check("016b accept edge", 64'(acc_edge[1]), 64'd769);
    check("faad accept edge", 64'(acc_edge[2]), 64'd1025);

    // Reset mid left slot while 5555 plays and 7fff sits in the buffer.
    check("frame 7 underrun", 64'(underrun), 64'd0);
    pend.push_back(16'h7fff);
    repeat (10) tick();
    check("pre-reset bclk/dat/ready", 64'({aud_bclk, aud_dacdat, sample_ready}), 64'b110);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset clears outputs",
          64'({sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}), 64'd0);
    do_reset();
    run_frame("post-reset frame 0", 16'h0000, 1'b0, 1'b0, 16'h0);
    run_frame("post-reset frame 1", 16'h0000, 1'b1, 1'b0, 16'h0);

    // Sample offered exactly on the frame-start clock with the buffer empty.
    run_frame("post-reset frame 2", 16'h0000, 1'b1, 1'b1, 16'h0001);
    check("late sample accept edge", 64'(acc_edge.size() > 0 ? acc_edge[0] : 0), 64'd768);
    run_frame("post-reset frame 3", 16'h0000, 1'b1, 1'b0, 16'h0);
    run_frame("post-reset frame 4", 16'h0001, 1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
